// File: rtl/mul_pkg.sv
// Shared types and sizing constants for the sequential divider.
package mul_pkg;

    localparam int unsigned DivBitlen = 17;
    localparam int unsigned DivCntW   = (DivBitlen > 1) ? $clog2(DivBitlen) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/mul_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module mul_div_step #(
    parameter int unsigned BITLEN = 17
) (
    input  logic [BITLEN:0]   rem_i,
    input  logic              qsh_msb_i,
    input  logic [BITLEN-1:0] b_i,
    output logic [BITLEN:0]   rem_o,
    output logic              q_bit_o
);

    logic [BITLEN:0]   shifted;
    logic [BITLEN+1:0] trial;

    // rem_i < b_i always holds, so rem_i[BITLEN] is zero and can be dropped by the shift.
    assign shifted = {rem_i[BITLEN-1:0], qsh_msb_i};
    assign trial   = {1'b0, shifted} - {2'b00, b_i};

    always_comb begin
        q_bit_o = ~trial[BITLEN+1];
        rem_o   = q_bit_o ? trial[BITLEN:0] : shifted;
    end

endmodule

// File: rtl/mul_div_seq.sv
// Sequential radix-2 restoring divider: 2*BITLEN-bit dividend by BITLEN-bit divisor,
// one quotient bit per cycle, valid/ready on both sides.
module mul_div_seq
    import mul_pkg::*;
#(
    parameter int unsigned BITLEN = DivBitlen
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*BITLEN-1:0] C,
    input  logic [BITLEN-1:0]   B,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITLEN-1:0]   Q,
    output logic [BITLEN-1:0]   R,
    output logic                err
);

    localparam int unsigned CntW = (BITLEN > 1) ? $clog2(BITLEN) : 1;

    div_state_t          state_q, state_d;
    logic [BITLEN:0]     rem_q, rem_d;
    logic [BITLEN-1:0]   qsh_q, qsh_d;
    logic [BITLEN-1:0]   b_q, b_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [BITLEN:0]     step_rem;
    logic                step_qbit;
    logic [BITLEN-1:0]   c_hi;
    logic                div_err;

    assign c_hi    = C[2*BITLEN-1:BITLEN];
    // A high half at or above the divisor means the quotient cannot fit BITLEN bits.
    assign div_err = (B == '0) || (c_hi >= B);

    mul_div_step #(
        .BITLEN (BITLEN)
    ) u_step (
        .rem_i     (rem_q),
        .qsh_msb_i (qsh_q[BITLEN-1]),
        .b_i       (b_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        qsh_d   = qsh_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    b_d = B;
                    if (div_err) begin
                        err_d   = 1'b1;
                        qsh_d   = '1;
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        rem_d   = {1'b0, c_hi};
                        qsh_d   = C[BITLEN-1:0];
                        cnt_d   = CntW'(BITLEN - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = step_rem;
                qsh_d = {qsh_q[BITLEN-2:0], step_qbit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            qsh_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            qsh_q   <= qsh_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Q         = qsh_q;
    assign R         = rem_q[BITLEN-1:0];
    assign err       = err_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq: directed table, handshake corner cases, random vectors.
module tb_mul_div_seq;

    localparam int unsigned W = 17;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] C;
    logic [W-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   Q;
    logic [W-1:0]   R;
    logic           err;

    int errors = 0;
    int checks = 0;

    mul_div_seq #(
        .BITLEN (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (C),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [2*W-1:0] c;
        logic [W-1:0]   b;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           e;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Division defined directly from the arithmetic: quotient must fit W bits.
    function automatic void ref_div(input logic [2*W-1:0] c, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic e);
        logic [2*W-1:0] bq, qq;
        bq = {{W{1'b0}}, b};
        if (b == '0) begin
            e = 1'b1; q = '1; r = '0;
        end else begin
            qq = c / bq;
            if (qq > {{W{1'b0}}, {W{1'b1}}}) begin
                e = 1'b1; q = '1; r = '0;
            end else begin
                e = 1'b0; q = qq[W-1:0]; r = W'(c % bq);
            end
        end
    endfunction

    task automatic start_op(input string nm, input logic [2*W-1:0] c, input logic [W-1:0] b);
        @(negedge clk);
        chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        C        = c;
        B        = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        C        = {$urandom, $urandom};
        B        = W'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic take_result(input string nm, input int stall);
        repeat (stall) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, ".out_valid_after"}, 64'(out_valid), 64'd0);
        chk({nm, ".in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input string nm, input logic [2*W-1:0] c, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ee,
                         input int stall);
        int n;
        start_op(nm, c, b);
        wait_valid(n);
        chk({nm, ".latency"}, 64'(n), ee ? 64'd0 : 64'(W));
        chk({nm, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({nm, ".Q"}, 64'(Q), 64'(eq));
        chk({nm, ".R"}, 64'(R), 64'(er));
        chk({nm, ".err"}, 64'(err), 64'(ee));
        take_result(nm, stall);
    endtask

    vec_t vecs[6];

    initial begin
        int n;
        int seen;
        logic [W-1:0]   a, b, r, mq, mr;
        logic           me;
        logic [2*W-1:0] c;

        vecs[0] = '{"basic",   34'd1000, 17'd7, 17'd142, 17'd6, 1'b0};
        vecs[1] = '{"maxops",  34'h1FFFF * 34'h1FFFF + 34'h1FFFE, 17'h1FFFF,
                    17'h1FFFF, 17'h1FFFE, 1'b0};
        vecs[2] = '{"divzero", 34'h2_3456_789A, 17'd0, 17'h1FFFF, 17'd0, 1'b1};
        vecs[3] = '{"ovf_eq",  (34'd5 << W) | 34'd123, 17'd5, 17'h1FFFF, 17'd0, 1'b1};
        vecs[4] = '{"small",   34'd100, 17'd9, 17'd11, 17'd1, 1'b0};
        vecs[5] = '{"zero_c",  34'd0, 17'd3, 17'd0, 17'd0, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        C         = '0;
        B         = '0;
        #1;
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.Q", 64'(Q), 64'd0);
        chk("reset.R", 64'(R), 64'd0);
        chk("reset.err", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].name, vecs[i].c, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e, 0);
        end

        // Consumer stalls for 10 cycles while new requests are offered.
        start_op("stall", 34'd1000, 17'd7);
        wait_valid(n);
        chk("stall.latency", 64'(n), 64'(W));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            C        = 34'd55;
            B        = 17'd3;
            @(posedge clk);
            #1;
            chk("stall.out_valid", 64'(out_valid), 64'd1);
            chk("stall.in_ready", 64'(in_ready), 64'd0);
            chk("stall.Q", 64'(Q), 64'd142);
            chk("stall.R", 64'(R), 64'd6);
            chk("stall.err", 64'(err), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        take_result("stall", 0);
        @(posedge clk);
        #1;
        chk("stall.idle_next", 64'(in_ready), 64'd1);
        chk("stall.no_extra", 64'(out_valid), 64'd0);

        // Reset during BUSY discards the operation.
        start_op("rst", 34'h1FFFF * 34'h1FFFF, 17'h1FFFF);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.Q", 64'(Q), 64'd0);
        chk("rst.R", 64'(R), 64'd0);
        chk("rst.err", 64'(err), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b1;
        C        = 34'd77;
        B        = 17'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        seen     = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("rst.no_out_valid", 64'(seen), 64'd0);
        do_op("after_rst", 34'd100, 17'd9, 17'd11, 17'd1, 1'b0, 0);

        // Round trip through the product: C = A*B + r with r < B.
        for (int i = 0; i < 500; i++) begin
            a = W'($urandom);
            b = W'($urandom_range(1, (1 << W) - 1));
            r = W'($urandom_range(0, int'(b) - 1));
            c = {{W{1'b0}}, a} * {{W{1'b0}}, b} + {{W{1'b0}}, r};
            do_op("rand_rt", c, b, a, r, 1'b0, $urandom_range(0, 2));
        end

        // Unconstrained operands, overflow and small divisors included.
        for (int i = 0; i < 300; i++) begin
            c = {$urandom, $urandom};
            if (i % 3 == 0) c = c >> (W + 4);
            b = (i % 7 == 0) ? W'(0) : W'($urandom >> $urandom_range(0, 16));
            ref_div(c, b, mq, mr, me);
            do_op("rand_raw", c, b, mq, mr, me, $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
